// File: rtl/hit_pulse_generator.sv
// Turns per-pixel collision levels into one-clock hit pulses: one evaluation per frame,
// frame-to-frame edge detection, per-object lockout, operands serialized before numbers.
module hit_pulse_generator #(
   parameter int NUMBERS        = 9,
   parameter int LOCKOUT_FRAMES = 30
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic [NUMBERS-1:0] collisionNumbers,
   input  logic [1:0]         collisionOperands,
   output logic [NUMBERS-1:0] SingleHitPulse,
   output logic [1:0]         operandHit,
   output logic [7:0]         hitCount,
   output logic               busy
);

   localparam int OBJS = NUMBERS + 2;
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] EVAL      = 2'd1;
   localparam logic [1:0] DRAIN_OP  = 2'd2;
   localparam logic [1:0] DRAIN_NUM = 2'd3;
   localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_FRAMES);

   logic [1:0]            state;
   logic [OBJS-1:0]       coll;
   logic [OBJS-1:0]       frameFlag;
   logic [OBJS-1:0]       prevFlag;
   logic [OBJS-1:0]       pending;
   logic [OBJS-1:0]       newHit;
   logic [OBJS-1:0][7:0]  lock;
   logic                  sofPending;
   logic [NUMBERS-1:0]    numPend, numSel, numLeft;
   logic [1:0]            opPend, opSel, opLeft;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] lock_dec(input logic [7:0] v);
      return (v == 8'd0) ? v : v - 8'd1;
   endfunction

   // Object vector layout: numbers in the low bits, plus then minus on top.
   assign coll    = {collisionOperands, collisionNumbers};
   assign numPend = pending[NUMBERS-1:0];
   assign opPend  = pending[NUMBERS +: 2];
   assign numSel  = numPend & (~numPend + NUMBERS'(1));
   assign numLeft = numPend & ~numSel;
   assign opSel   = opPend[0] ? 2'b01 : {opPend[1], 1'b0};
   assign opLeft  = opPend & ~opSel;

   // frameFlag already holds the inputs sampled on the SOF edge, so it is the snapshot.
   always_comb begin
      newHit = '0;
      for (int k = 0; k < OBJS; k++)
         newHit[k] = frameFlag[k] & ~prevFlag[k] & (lock[k] == 8'd0) & enable;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state          <= IDLE;
         frameFlag      <= '0;
         prevFlag       <= '0;
         pending        <= '0;
         lock           <= '0;
         sofPending     <= 1'b0;
         SingleHitPulse <= '0;
         operandHit     <= '0;
         hitCount       <= '0;
         busy           <= 1'b0;
      end else begin
         SingleHitPulse <= '0;
         operandHit     <= '0;
         busy           <= (state != IDLE);
         if (state != EVAL)
            frameFlag <= frameFlag | coll;
         if (startOfFrame && (state != IDLE))
            sofPending <= 1'b1;

         case (state)
            IDLE: begin
               if (startOfFrame || sofPending) begin
                  state      <= EVAL;
                  sofPending <= 1'b0;
               end
            end
            EVAL: begin
               prevFlag  <= frameFlag;
               frameFlag <= coll;
               pending   <= newHit;
               for (int k = 0; k < OBJS; k++)
                  lock[k] <= newHit[k] ? LOCK_LOAD : lock_dec(lock[k]);
               if (|newHit[NUMBERS +: 2])
                  state <= DRAIN_OP;
               else if (|newHit[NUMBERS-1:0])
                  state <= DRAIN_NUM;
               else
                  state <= IDLE;
            end
            DRAIN_OP: begin
               if (!enable) begin
                  pending <= '0;
                  state   <= IDLE;
               end else begin
                  operandHit            <= opSel;
                  pending[NUMBERS +: 2] <= opLeft;
                  if (|opPend)
                     hitCount <= sat_inc(hitCount);
                  if (opLeft == 2'b00)
                     state <= (|numPend) ? DRAIN_NUM : IDLE;
               end
            end
            default: begin
               if (!enable) begin
                  pending <= '0;
                  state   <= IDLE;
               end else begin
                  SingleHitPulse        <= numSel;
                  pending[NUMBERS-1:0]  <= numLeft;
                  if (|numPend)
                     hitCount <= sat_inc(hitCount);
                  if (numLeft == '0)
                     state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hit_pulse_generator.sv
// Directed bench for hit_pulse_generator: a table of per-frame vectors plus
// hand-written sequences for SOF coincidence, deferred SOF, reset mid-burst and saturation.
module tb_hit_pulse_generator;

   localparam int N = 9;

   logic         clk = 1'b0;
   logic         resetN = 1'b0;
   logic         startOfFrame = 1'b0;
   logic         enable = 1'b0;
   logic [N-1:0] collisionNumbers = '0;
   logic [1:0]   collisionOperands = '0;
   logic [N-1:0] SingleHitPulse;
   logic [1:0]   operandHit;
   logic [7:0]   hitCount;
   logic         busy;

   int checks = 0;
   int errors = 0;

   hit_pulse_generator #(.NUMBERS(N), .LOCKOUT_FRAMES(3)) dut (
      .clk               (clk),
      .resetN            (resetN),
      .startOfFrame      (startOfFrame),
      .enable            (enable),
      .collisionNumbers  (collisionNumbers),
      .collisionOperands (collisionOperands),
      .SingleHitPulse    (SingleHitPulse),
      .operandHit        (operandHit),
      .hitCount          (hitCount),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] nums;
      logic [1:0]   ops;
      logic         en;
      logic [N-1:0] xnums;
      logic [1:0]   xops;
      logic [7:0]   xcnt;
   } vec_t;

   vec_t vecs [23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pulses();
      return 32'({operandHit, SingleHitPulse});
   endfunction

   // Hold collisions for a few cycles, drop them, then a one-clock SOF.
   // Returns at the falling edge just after the SOF-sampling edge.
   task automatic send_frame(input logic [N-1:0] nums, input logic [1:0] ops, input logic en);
      @(negedge clk);
      enable = en;
      collisionNumbers = nums;
      collisionOperands = ops;
      repeat (4) @(negedge clk);
      collisionNumbers = '0;
      collisionOperands = '0;
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   // Expect the given hits as back-to-back pulses: plus, minus, then numbers ascending.
   task automatic expect_burst(input string name, input logic [N-1:0] xn, input logic [1:0] xo,
                               input logic [7:0] xcnt);
      logic [N+1:0] rem;
      logic [N+1:0] exp1;
      logic         found;
      rem = {xo, xn};
      @(posedge clk); #1;
      check({name, " eval quiet"}, pulses(), 32'd0);
      check({name, " busy eval"}, 32'(busy), 32'd1);
      while (rem != '0) begin
         exp1 = '0;
         found = 1'b0;
         if (rem[N]) exp1[N] = 1'b1;
         else if (rem[N+1]) exp1[N+1] = 1'b1;
         else
            for (int i = 0; i < N; i++)
               if (rem[i] && !found) begin
                  exp1[i] = 1'b1;
                  found = 1'b1;
               end
         @(posedge clk); #1;
         check({name, " pulse"}, pulses(), 32'(exp1));
         rem = rem & ~exp1;
      end
      @(posedge clk); #1;
      check({name, " after"}, pulses(), 32'd0);
      check({name, " busy end"}, 32'(busy), 32'd0);
      check({name, " count"}, 32'(hitCount), 32'(xcnt));
   endtask

   // Drive a frame without per-pulse checks; wait (bounded) for the drain to finish.
   task automatic run_quiet(input logic [N-1:0] nums, input logic [1:0] ops);
      int n;
      send_frame(nums, ops, 1'b1);
      @(posedge clk);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy && n < 20);
      check("sat drain done", 32'(busy), 32'd0);
   endtask

   initial begin
      int bad;
      vecs[0]  = '{9'h008, 2'b00, 1'b1, 9'h008, 2'b00, 8'd1};
      vecs[1]  = '{9'h081, 2'b10, 1'b1, 9'h081, 2'b10, 8'd4};
      vecs[2]  = '{9'h004, 2'b00, 1'b1, 9'h004, 2'b00, 8'd5};
      vecs[3]  = '{9'h004, 2'b00, 1'b1, 9'h000, 2'b00, 8'd5};
      vecs[4]  = '{9'h004, 2'b00, 1'b1, 9'h000, 2'b00, 8'd5};
      vecs[5]  = '{9'h004, 2'b00, 1'b1, 9'h000, 2'b00, 8'd5};
      vecs[6]  = '{9'h004, 2'b00, 1'b1, 9'h000, 2'b00, 8'd5};
      vecs[7]  = '{9'h020, 2'b00, 1'b1, 9'h020, 2'b00, 8'd6};
      vecs[8]  = '{9'h000, 2'b00, 1'b1, 9'h000, 2'b00, 8'd6};
      vecs[9]  = '{9'h020, 2'b00, 1'b1, 9'h000, 2'b00, 8'd6};
      vecs[10] = '{9'h000, 2'b00, 1'b1, 9'h000, 2'b00, 8'd6};
      vecs[11] = '{9'h020, 2'b00, 1'b1, 9'h020, 2'b00, 8'd7};
      vecs[12] = '{9'h000, 2'b00, 1'b1, 9'h000, 2'b00, 8'd7};
      vecs[13] = '{9'h020, 2'b00, 1'b1, 9'h000, 2'b00, 8'd7};
      vecs[14] = '{9'h003, 2'b01, 1'b0, 9'h000, 2'b00, 8'd7};
      vecs[15] = '{9'h003, 2'b01, 1'b1, 9'h000, 2'b00, 8'd7};
      vecs[16] = '{9'h000, 2'b00, 1'b1, 9'h000, 2'b00, 8'd7};
      vecs[17] = '{9'h003, 2'b01, 1'b1, 9'h003, 2'b01, 8'd10};
      vecs[18] = '{9'h1FF, 2'b11, 1'b1, 9'h1FC, 2'b10, 8'd18};
      for (int i = 19; i < 23; i++)
         vecs[i] = '{9'h000, 2'b00, 1'b1, 9'h000, 2'b00, 8'd18};

      #2;
      check("reset pulses", pulses(), 32'd0);
      check("reset count", 32'(hitCount), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < 23; i++) begin
         send_frame(vecs[i].nums, vecs[i].ops, vecs[i].en);
         expect_burst($sformatf("v%0d", i), vecs[i].xnums, vecs[i].xops, vecs[i].xcnt);
      end

      // Collision on the SOF edge belongs to the ending frame; one during EVAL to the next.
      @(negedge clk);
      enable = 1'b1;
      collisionNumbers = 9'h010;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      collisionNumbers = 9'h040;
      @(negedge clk);
      collisionNumbers = '0;
      @(posedge clk); #1;
      check("sof coincident pulse", pulses(), 32'h010);
      @(posedge clk); #1;
      check("sof coincident after", pulses(), 32'd0);
      check("sof coincident count", 32'(hitCount), 32'd19);
      send_frame('0, 2'b00, 1'b1);
      expect_burst("eval-cycle hit", 9'h040, 2'b00, 8'd20);
      for (int i = 0; i < 4; i++) begin
         send_frame('0, 2'b00, 1'b1);
         expect_burst("gap", '0, 2'b00, 8'd20);
      end

      // Nine-pulse burst with an SOF and a plus collision arriving mid-drain.
      send_frame(9'h1FF, 2'b00, 1'b1);
      @(posedge clk); #1;
      check("burst busy", 32'(busy), 32'd1);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         check($sformatf("burst pulse %0d", i), pulses(), 32'(1) << i);
         if (i == 2) begin
            @(negedge clk);
            collisionOperands = 2'b01;
            startOfFrame = 1'b1;
         end else if (i == 3) begin
            @(negedge clk);
            collisionOperands = 2'b00;
            startOfFrame = 1'b0;
         end
      end
      @(posedge clk); #1;
      check("deferred gap1", pulses(), 32'd0);
      @(posedge clk); #1;
      check("deferred gap2", pulses(), 32'd0);
      check("deferred busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("deferred plus", 32'(operandHit), 32'd1);
      check("deferred nums", 32'(SingleHitPulse), 32'd0);
      @(posedge clk); #1;
      check("deferred after", pulses(), 32'd0);
      check("deferred count", 32'(hitCount), 32'd30);
      for (int i = 0; i < 4; i++) begin
         send_frame('0, 2'b00, 1'b1);
         expect_burst("gap2", '0, 2'b00, 8'd30);
      end

      // Asynchronous reset in the middle of a burst.
      send_frame(9'h1FF, 2'b00, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre-reset pulse0", pulses(), 32'h001);
      @(posedge clk); #1;
      check("pre-reset pulse1", pulses(), 32'h002);
      #2 resetN = 1'b0;
      #1;
      check("mid reset pulses", pulses(), 32'd0);
      check("mid reset count", 32'(hitCount), 32'd0);
      check("mid reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (pulses() != 32'd0 || busy) bad++;
      end
      check("post reset quiet cycles", 32'(bad), 32'd0);
      check("post reset count", 32'(hitCount), 32'd0);

      // Saturation: 11 hits every 4 frames.
      for (int b = 0; b < 23; b++) begin
         run_quiet(9'h1FF, 2'b11);
         repeat (3) run_quiet('0, 2'b00);
      end
      check("count 253", 32'(hitCount), 32'd253);
      for (int b = 0; b < 5; b++) begin
         run_quiet(9'h1FF, 2'b11);
         repeat (3) run_quiet('0, 2'b00);
      end
      check("count saturated", 32'(hitCount), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hit_pulse_generator.md
# hit_pulse_generator

Converts the raw per-pixel collision levels from the VGA object drawers into clean, one-clock hit events for the score controller. Each collision is evaluated once per frame, edge-detected across frames, rate-limited by a per-object lockout, then serialized: operand pulses first, then number pulses, one per clock. It sits directly upstream of the score controller and drives its `SingleHitPulse` and `operandHit` inputs.

## Interface
- `NUMBERS`, 9, number of number-objects on screen.
- `LOCKOUT_FRAMES`, 30, frames an object stays ignored after it produces a hit (1..255).
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-clock pulse marking the frame boundary.
- `enable`  in  1  game running. When low, no new hits are generated.
- `collisionNumbers`  in  NUMBERS  level: player pixel overlaps number i this cycle.
- `collisionOperands`  in  2  level. Bit 0 = plus object, bit 1 = minus object.
- `SingleHitPulse`  out  NUMBERS  registered one-hot one-clock pulse per number hit.
- `operandHit`  out  2  registered one-hot one-clock pulse per operand hit.
- `hitCount`  out  8  total pulses issued, saturating at 255.
- `busy`  out  1  high while in EVAL or draining.

## Operation
- **Frame flags.** `frameFlag[k]` is set on any cycle the corresponding collision input is high. This applies to the NUMBERS+2 objects: numbers 0..N-1, then operands. Flags are sticky within the frame.
- **Previous-frame flags.** `prevFlag[k]` is the flag snapshot from the previous frame. It provides frame-to-frame edge detection, so a hit requires the object to have been untouched in the preceding frame.
- **Lockout counters.** `lock[k]` is an 8-bit counter per object.
- **FSM states:** IDLE, EVAL, DRAIN_OP, DRAIN_NUM.
- **IDLE**
  - Accumulate flags.
  - On an edge with `startOfFrame` high (or `sofPending` set), go to EVAL and clear `sofPending`.
- **EVAL** (exactly 1 cycle)
  - `snap = frameFlag | inputs sampled on the SOF edge`.
  - `newHit[k] = snap[k] & ~prevFlag[k] & (lock[k]==0) & enable`.
  - `prevFlag <= snap`. `frameFlag <= 0`; collisions during EVAL go into the new frame.
  - `lock[k] <= LOCKOUT_FRAMES` where `newHit[k]`; otherwise decrement if nonzero.
  - `pending <= newHit`.
  - Next state: DRAIN_OP if any operand is pending, else DRAIN_NUM if any number is pending, else IDLE.
- **DRAIN_OP**
  - Each cycle, pulse the lowest pending operand (plus before minus) and clear its pending bit.
  - When no operands remain, go to DRAIN_NUM, or to IDLE if no numbers are pending.
- **DRAIN_NUM**
  - Each cycle, pulse the lowest pending number index and clear it.
  - Go to IDLE after the last pulse.
- **Ordering.** Operands are issued first so the score controller switches its plus/minus mode before the numbers of the same frame arrive.
- **Hit counter.** `hitCount` increments by 1 per pulse issued and saturates at 255.
- **SOF while busy.** `startOfFrame` arriving while not in IDLE sets `sofPending`. Flags keep accumulating. The evaluation runs on return to IDLE, and only one evaluation is deferred.
- **`enable` low**
  - `pending` is cleared and DRAIN states exit to IDLE on the next edge.
  - EVAL still updates `prevFlag` and decrements locks; it produces no hits.

## Timing
- **Reset values.** All outputs 0. FSM in IDLE. `frameFlag`, `prevFlag`, `lock`, `pending`, `sofPending` = 0.
- **Latency.** SOF sampled at edge k; EVAL runs k..k+1; first pulse is high from edge k+2 to k+3. Subsequent pulses follow on consecutive cycles with no gaps.
- **Burst length.** Worst case is NUMBERS+2 consecutive pulses. `busy` is high from edge k+1 until the edge after the last pulse.
- **Pulse properties.** Each pulse is exactly 1 clock wide. At most one bit across `SingleHitPulse` and `operandHit` is high in any cycle.
- **Collision coincident with SOF.** Counts toward the ending frame.
- **Lockout wrap.** Counters never wrap below 0. A hit reloads the counter regardless of its current value; this can only happen when it is 0.
- **Reset mid-drain.** Outputs drop within the same cycle (asynchronous). Remaining pending hits are lost.

## Test plan
- **Single number hit.** Hold `collisionNumbers[3]` high for 50 cycles in frame 1, then SOF → `SingleHitPulse = 9'b000001000` for 1 clock, 2 clocks after SOF; `hitCount = 1`.
- **Operand before number.** Frame with `collisionOperands[1]` and `collisionNumbers[0]`, `[7]` set, then SOF → `operandHit = 2'b10`, then pulse 0, then pulse 7, on 3 consecutive cycles; `busy` high for 4 cycles.
- **Sustained overlap.** Hold `collisionNumbers[2]` high across 5 frames → exactly one pulse, after the first SOF.
- **Lockout.** `LOCKOUT_FRAMES = 3`. Touch number 5 in frames 1, 3, 5, 7 → pulses after frames 1 and 5 only.
- **Disabled / saturation.** `enable = 0` with collisions → no pulses and `hitCount` unchanged. Forcing 300 hits → `hitCount = 255`.
- **SOF while busy and reset mid-drain.**
  - SOF asserted during a 9-pulse burst → the deferred EVAL runs on return to IDLE.
  - `resetN` low mid-burst → all outputs 0 immediately, and no pulses after release.
